// File: rtl/sd_bd_ctrl_pkg.sv
// rtl/sd_bd_ctrl_pkg.sv - shared constants and types for the buffer-descriptor store
package sd_bd_ctrl_pkg;

    localparam int BD_DEPTH      = 8;
    localparam int BD_WIDTH      = 5;
    localparam int PTR_W         = 3;
    localparam int BD_SIZE       = 2;   // words per descriptor: sys_adr, cmd_arg
    localparam int RAM_MEM_WIDTH = 32;

    // Progress of the current fetch burst through the head descriptor
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_WORD1 = 2'd1,
        RD_DONE  = 2'd2
    } rd_word_t;

endpackage

// File: rtl/sd_bd_ram.sv
// rtl/sd_bd_ram.sv - simple dual-port descriptor RAM, synchronous write and read
import sd_bd_ctrl_pkg::*;

module sd_bd_ram #(
    parameter int AW = PTR_W + $clog2(BD_SIZE),
    parameter int DW = RAM_MEM_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register doubles as the published read data, so it carries a reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_bd_ctrl.sv
// rtl/sd_bd_ctrl.sv - descriptor store with host push port and master fetch/retire responder
module sd_bd_ctrl
    import sd_bd_ctrl_pkg::*;
#(
    parameter int BD_DEPTH = sd_bd_ctrl_pkg::BD_DEPTH,
    parameter int BD_WIDTH = sd_bd_ctrl_pkg::BD_WIDTH,
    parameter int PTR_W    = sd_bd_ctrl_pkg::PTR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_m,
    input  logic [31:0]         dat_in_m,
    input  logic                bd_clr,
    output logic [BD_WIDTH-1:0] free_bd,
    output logic                wr_err,
    input  logic                re_s,
    output logic                ack_o_s,
    output logic [31:0]         dat_out_s,
    input  logic                a_cmp,
    output logic                cmp_err
);

    localparam int AW = PTR_W + 1;
    localparam logic [BD_WIDTH-1:0] EMPTY_CNT = BD_WIDTH'(BD_DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_half;
    rd_word_t         rd_word, rd_word_nxt;
    logic             re_q, a_cmp_q;
    logic             empty, full, wr_ok, commit, cmp_rise, retire;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;

    assign empty    = (free_bd == EMPTY_CNT);
    assign full     = (free_bd == '0);
    assign wr_ok    = we_m && !full && !bd_clr;
    assign commit   = wr_ok && wr_half;
    assign cmp_rise = a_cmp && !a_cmp_q;
    assign retire   = cmp_rise && !empty && !bd_clr;

    always_ff @(posedge clk) begin
        if (rst || bd_clr) begin
            rd_word <= RD_IDLE;
        end else begin
            rd_word <= rd_word_nxt;
        end
    end

    // A fresh re_s edge always restarts from word 0, which is what makes retries work
    always_comb begin
        rd_word_nxt = rd_word;
        if (retire) begin
            rd_word_nxt = RD_IDLE;
        end else if (re_s && !empty) begin
            if (!re_q) begin
                rd_word_nxt = RD_WORD1;
            end else if (rd_word == RD_WORD1) begin
                rd_word_nxt = RD_DONE;
            end
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {rd_ptr, 1'b0};
        if (!bd_clr && !retire && re_s && !empty) begin
            if (!re_q) begin
                rd_en = 1'b1;
            end else if (rd_word == RD_WORD1) begin
                rd_en   = 1'b1;
                rd_addr = {rd_ptr, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bd_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_half <= 1'b0;
            free_bd <= EMPTY_CNT;
            ack_o_s <= 1'b0;
            wr_err  <= 1'b0;
            cmp_err <= 1'b0;
        end else begin
            ack_o_s <= rd_en;
            if (we_m) begin
                if (full) begin
                    wr_err <= 1'b1;
                end else begin
                    wr_half <= ~wr_half;
                end
            end
            if (commit) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cmp_rise && empty) begin
                cmp_err <= 1'b1;
            end
            // Coincident commit and retire cancel out on the free count
            if (commit && !retire) begin
                free_bd <= free_bd - BD_WIDTH'(1);
            end else if (retire && !commit) begin
                free_bd <= free_bd + BD_WIDTH'(1);
            end
        end
    end

    // Edge detectors keep tracking their inputs through a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            re_q    <= 1'b0;
            a_cmp_q <= 1'b0;
        end else begin
            re_q    <= re_s;
            a_cmp_q <= a_cmp;
        end
    end

    sd_bd_ram #(
        .AW (AW),
        .DW (32)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr ({wr_ptr, wr_half}),
        .wdata (dat_in_m),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (dat_out_s)
    );

endmodule

// File: tb/tb_sd_bd_ctrl.sv
// tb/tb_sd_bd_ctrl.sv - randomized self-checking bench for sd_bd_ctrl against a queue model
module tb_sd_bd_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_m;
    logic [31:0] dat_in_m;
    logic        bd_clr;
    logic [4:0]  free_bd;
    logic        wr_err;
    logic        re_s;
    logic        ack_o_s;
    logic [31:0] dat_out_s;
    logic        a_cmp;
    logic        cmp_err;

    always #5 clk = ~clk;

    sd_bd_ctrl #(
        .BD_DEPTH (8),
        .BD_WIDTH (5),
        .PTR_W    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we_m      (we_m),
        .dat_in_m  (dat_in_m),
        .bd_clr    (bd_clr),
        .free_bd   (free_bd),
        .wr_err    (wr_err),
        .re_s      (re_s),
        .ack_o_s   (ack_o_s),
        .dat_out_s (dat_out_s),
        .a_cmp     (a_cmp),
        .cmp_err   (cmp_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: committed descriptors in FIFO order, plus a pending first word
    logic [63:0] q[$];
    logic [31:0] pend;
    bit          half;
    bit          m_wr_err;
    bit          m_cmp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".free_bd"}, 32'(free_bd), 32'(DEPTH - q.size()));
        check({tag, ".wr_err"}, 32'(wr_err), 32'(m_wr_err));
        check({tag, ".cmp_err"}, 32'(cmp_err), 32'(m_cmp_err));
    endtask

    task automatic model_clear();
        q.delete();
        half      = 1'b0;
        m_wr_err  = 1'b0;
        m_cmp_err = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] w);
        if (q.size() == DEPTH) begin
            m_wr_err = 1'b1;
        end else if (!half) begin
            pend = w;
            half = 1'b1;
        end else begin
            q.push_back({pend, w});
            half = 1'b0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        we_m     = 1'b1;
        dat_in_m = w;
        cyc();
        we_m     = 1'b0;
        model_push(w);
    endtask

    task automatic fetch(input string tag);
        int          acks;
        int          pos0;
        int          pos1;
        int          exp_acks;
        logic [31:0] d0;
        logic [31:0] d1;
        acks     = 0;
        pos0     = -1;
        pos1     = -1;
        d0       = '0;
        d1       = '0;
        exp_acks = (q.size() != 0) ? 2 : 0;
        re_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (ack_o_s) begin
                if (acks == 0) begin
                    d0   = dat_out_s;
                    pos0 = i;
                end else if (acks == 1) begin
                    d1   = dat_out_s;
                    pos1 = i;
                end
                acks++;
            end
        end
        re_s = 1'b0;
        cyc();
        check({tag, ".acks"}, 32'(acks), 32'(exp_acks));
        if (exp_acks == 2) begin
            check({tag, ".sys_adr"}, d0, q[0][63:32]);
            check({tag, ".cmd_arg"}, d1, q[0][31:0]);
            check({tag, ".back2back"}, 32'(pos1 - pos0), 32'd1);
        end
    endtask

    task automatic retire(input string tag, input int len);
        a_cmp = 1'b1;
        repeat (len) cyc();
        a_cmp = 1'b0;
        cyc();
        if (q.size() == 0) begin
            m_cmp_err = 1'b1;
        end else begin
            void'(q.pop_front());
        end
        check_state(tag);
    endtask

    task automatic flush(input string tag);
        bd_clr = 1'b1;
        cyc();
        bd_clr = 1'b0;
        model_clear();
        check_state(tag);
    endtask

    initial begin
        int          exp_free;
        logic [31:0] w;
        rst      = 1'b1;
        we_m     = 1'b0;
        dat_in_m = '0;
        bd_clr   = 1'b0;
        re_s     = 1'b0;
        a_cmp    = 1'b0;
        model_clear();
        repeat (2) cyc();
        check("reset.ack_o_s", 32'(ack_o_s), 32'd0);
        check("reset.dat_out_s", dat_out_s, 32'd0);
        check_state("reset");
        rst = 1'b0;
        cyc();

        // Single descriptor
        push_word(32'h0000_1000);
        check("single.free_after_w0", 32'(free_bd), 32'd8);
        push_word(32'h0000_0200);
        check("single.free_after_w1", 32'(free_bd), 32'd7);
        fetch("single");

        // Long a_cmp counts once
        retire("retire_long", 2);

        // Fill to full plus one descriptor
        for (int i = 0; i < 18; i++) begin
            push_word(32'hA000_0000 + 32'(i));
        end
        check("fill.free_bd", 32'(free_bd), 32'd0);
        check("fill.wr_err", 32'(wr_err), 32'd1);
        for (int i = 0; i < 9; i++) begin
            fetch("fill.drain");
            retire("fill.retire", 1);
        end
        flush("fill.flush");

        // Wrap past slot 7
        for (int i = 0; i < 12; i++) begin
            push_word($urandom);
            push_word($urandom);
            fetch("wrap");
            retire("wrap.retire", 1);
        end

        // Retry re-reads the head; then coincident commit and retire
        push_word(32'h1234_5678);
        push_word(32'h9ABC_DEF0);
        fetch("retry1");
        fetch("retry2");
        push_word(32'h5555_0000);
        exp_free = DEPTH - q.size();
        a_cmp    = 1'b1;
        we_m     = 1'b1;
        dat_in_m = 32'h5555_0001;
        cyc();
        we_m  = 1'b0;
        a_cmp = 1'b0;
        check("coincident.free_bd", 32'(free_bd), 32'(exp_free));
        cyc();
        void'(q.pop_front());
        model_push(32'h5555_0001);
        check_state("coincident");
        fetch("coincident.head");
        retire("coincident.retire", 1);

        // Flush mid-burst with three descriptors queued
        flush("flush.pre");
        for (int i = 0; i < 6; i++) begin
            push_word(32'hF000_0000 + 32'(i));
        end
        re_s = 1'b1;
        cyc();
        check("flush.ack_before", 32'(ack_o_s), 32'd1);
        bd_clr = 1'b1;
        cyc();
        bd_clr = 1'b0;
        re_s   = 1'b0;
        model_clear();
        check("flush.ack_after", 32'(ack_o_s), 32'd0);
        check_state("flush.after");
        cyc();
        fetch("flush.refetch");

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                w = $urandom;
                push_word(w);
                check_state("rand.push");
            end else if (r < 70) begin
                fetch("rand.fetch");
            end else if (r < 94) begin
                retire("rand.retire", $urandom_range(1, 2));
            end else begin
                flush("rand.flush");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
